// File: rtl/arp_tx.sv
// ARP transmit framer: builds 4-beat ARP reply/request frames on AXI-Stream.
// Optional gratuitous ARP on local IP change: define ARP_TX_GRATUITOUS_EN.
module arp_tx #(
  parameter logic [31:0] P_SRC_IP_ADDR  = {8'd192, 8'd168, 8'd100, 8'd99},
  parameter logic [47:0] P_SRC_MAC_ADDR = 48'h01_02_03_04_05_06
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_recv_target_mac,
  input  logic [31:0] i_recv_target_ip,
  input  logic        i_recv_target_valid,
  input  logic        i_arp_reply,
  input  logic        i_arp_request,
  input  logic [31:0] i_request_ip,
  input  logic [31:0] i_dymanic_src_ip,
  input  logic        i_src_ip_valid,
  output logic [63:0] m_axis_arp_data,
  output logic [79:0] m_axis_arp_user,
  output logic [7:0]  m_axis_arp_keep,
  output logic        m_axis_arp_last,
  output logic        m_axis_arp_valid,
  input  logic        m_axis_arp_ready
);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_src_ip;
  logic [47:0] r_peer_mac;
  logic [31:0] r_peer_ip;
  logic        r_rep_pend;
  logic        r_req_pend;
  logic [31:0] r_req_ip;
  logic        w_grat_pend;

  logic [31:0] r_spa;
  logic [47:0] r_tha;
  logic [31:0] r_tpa;
  logic [1:0]  r_beat;

  logic        w_start;
  logic        w_hs;
  logic        w_take_rep;
  logic        w_take_req;
  logic        w_take_grat;
  logic [15:0] w_oper;
  logic [47:0] w_tha;
  logic [31:0] w_tpa;
  logic [47:0] w_dst;
  logic [1:0]  w_beat_nxt;
  logic [63:0] w_beat_data;

`ifdef ARP_TX_GRATUITOUS_EN
  logic r_grat_pend;

  // Gratuitous flag: set on every local IP update, cleared when served.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grat_pend <= 1'b0;
    end else if (i_src_ip_valid) begin
      r_grat_pend <= 1'b1;
    end else if (w_take_grat) begin
      r_grat_pend <= 1'b0;
    end
  end

  assign w_grat_pend = r_grat_pend;
`else
  assign w_grat_pend = 1'b0;
`endif

  // Local IP, captured peer and one-deep pending flags; a new strobe wins over a clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src_ip   <= P_SRC_IP_ADDR;
      r_peer_mac <= '0;
      r_peer_ip  <= '0;
      r_rep_pend <= 1'b0;
      r_req_pend <= 1'b0;
      r_req_ip   <= '0;
    end else begin
      if (i_src_ip_valid) begin
        r_src_ip <= i_dymanic_src_ip;
      end
      if (i_recv_target_valid) begin
        r_peer_mac <= i_recv_target_mac;
        r_peer_ip  <= i_recv_target_ip;
      end
      if (i_arp_reply) begin
        r_rep_pend <= 1'b1;
      end else if (w_take_rep) begin
        r_rep_pend <= 1'b0;
      end
      if (i_arp_request) begin
        r_req_pend <= 1'b1;
        r_req_ip   <= i_request_ip;
      end else if (w_take_req) begin
        r_req_pend <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, frame selection (reply > request > gratuitous) and field mux.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_hs        = 1'b0;
    w_take_rep  = 1'b0;
    w_take_req  = 1'b0;
    w_take_grat = 1'b0;
    w_oper      = 16'd1;
    w_tha       = '0;
    w_tpa       = '0;
    w_dst       = 48'hFFFF_FFFF_FFFF;
    case (r_state)
      S_IDLE: begin
        if (r_rep_pend) begin
          w_take_rep = 1'b1;
          w_oper     = 16'd2;
          w_tha      = r_peer_mac;
          w_tpa      = r_peer_ip;
          w_dst      = r_peer_mac;
        end else if (r_req_pend) begin
          w_take_req = 1'b1;
          w_tpa      = r_req_ip;
        end else if (w_grat_pend) begin
          w_take_grat = 1'b1;
          w_tpa       = r_src_ip;
        end
        w_start = w_take_rep | w_take_req | w_take_grat;
        if (w_start) begin
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        w_hs = m_axis_arp_valid & m_axis_arp_ready;
        if (w_hs && r_beat == 2'd3) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Payload of the beat following the current one.
  always_comb begin
    w_beat_nxt  = r_beat + 2'd1;
    w_beat_data = '0;
    unique case (w_beat_nxt)
      2'd1:    w_beat_data = {P_SRC_MAC_ADDR, r_spa[31:16]};
      2'd2:    w_beat_data = {r_spa[15:0], r_tha};
      2'd3:    w_beat_data = {r_tpa, 32'd0};
      default: w_beat_data = '0;
    endcase
  end

  // Frame fields are frozen at frame start so late strobes cannot alter it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_spa <= '0;
      r_tha <= '0;
      r_tpa <= '0;
    end else if (w_start) begin
      r_spa <= r_src_ip;
      r_tha <= w_tha;
      r_tpa <= w_tpa;
    end
  end

  // Registered stream outputs; beats advance only on valid && ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_axis_arp_data  <= '0;
      m_axis_arp_user  <= '0;
      m_axis_arp_keep  <= '0;
      m_axis_arp_last  <= 1'b0;
      m_axis_arp_valid <= 1'b0;
      r_beat           <= '0;
    end else if (w_start) begin
      m_axis_arp_data  <= {16'h0001, 16'h0800, 8'd6, 8'd4, w_oper};
      m_axis_arp_user  <= {w_dst, 16'd28, 16'h0806};
      m_axis_arp_keep  <= 8'hFF;
      m_axis_arp_last  <= 1'b0;
      m_axis_arp_valid <= 1'b1;
      r_beat           <= '0;
    end else if (w_hs) begin
      if (r_beat == 2'd3) begin
        m_axis_arp_valid <= 1'b0;
        m_axis_arp_last  <= 1'b0;
      end else begin
        r_beat          <= w_beat_nxt;
        m_axis_arp_data <= w_beat_data;
        m_axis_arp_keep <= (w_beat_nxt == 2'd3) ? 8'hF0 : 8'hFF;
        m_axis_arp_last <= (w_beat_nxt == 2'd3);
      end
    end
  end

endmodule
